// File: rtl/tmds_chan_decoder.sv
// TMDS receive channel decoder: bitslip-driven word alignment on control tokens,
// then per-word decode to pixel data or the c1/c0 control pair.
module tmds_chan_decoder #(
  parameter int TOKEN_RUN  = 8,
  parameter int SEARCH_LEN = 2048,
  parameter int SLIP_WAIT  = 16,
  parameter int LOSS_LEN   = 65536
) (
  input  logic       pclk,
  input  logic       rstbtn_n,
  input  logic [9:0] sdata,
  input  logic       sdata_vld,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_cnt,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       vld
);

  localparam int RW = $clog2(TOKEN_RUN + 1);
  localparam int SW = $clog2(SEARCH_LEN + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam int LW = $clog2(LOSS_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX    = RW'(TOKEN_RUN);
  localparam logic [SW-1:0] SEARCH_MAX = SW'(SEARCH_LEN);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(SLIP_WAIT);
  localparam logic [LW-1:0] LOSS_MAX   = LW'(LOSS_LEN);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Returns {is_token, c1, c0}.
  function automatic logic [2:0] tok_decode(input logic [9:0] w);
    logic [2:0] r;
    case (w)
      10'b1101010100: r = 3'b100;
      10'b0010101011: r = 3'b101;
      10'b0101010100: r = 3'b110;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] data_decode(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] q;
    d    = w[9] ? ~w[7:0] : w[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_run, w_run_nxt;
  logic [SW-1:0]   r_search, w_search_nxt;
  logic [WW-1:0]   r_wait, w_wait_nxt;
  logic [LW-1:0]   r_loss, w_loss_nxt;
  logic [2:0]      w_tok;
  logic            r_bitslip, r_aligned, r_c0, r_c1, r_de, r_vld;
  logic [3:0]      r_slip_cnt;
  logic [7:0]      r_dout;

  assign w_tok = tok_decode(sdata);

  // FSM and counter next-state; invalid cycles fall through holding everything
  // except the single-cycle SLIP state.
  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_search_nxt = r_search;
    w_wait_nxt   = r_wait;
    w_loss_nxt   = r_loss;
    case (r_state)
      ST_SEARCH: begin
        if (sdata_vld) begin
          w_run_nxt    = w_tok[2] ? (r_run + 1'b1) : {RW{1'b0}};
          w_search_nxt = r_search + 1'b1;
          if (w_run_nxt == RUN_MAX) begin
            w_state_nxt  = ST_LOCKED;
            w_run_nxt    = {RW{1'b0}};
            w_search_nxt = {SW{1'b0}};
            w_loss_nxt   = {LW{1'b0}};
          end else if (w_search_nxt == SEARCH_MAX) begin
            w_state_nxt  = ST_SLIP;
            w_run_nxt    = {RW{1'b0}};
            w_search_nxt = {SW{1'b0}};
          end else begin
            w_state_nxt  = ST_SEARCH;
          end
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_SLIP: begin
        // The word arriving alongside the pulse is the first discarded one.
        w_state_nxt = ST_WAIT;
        w_wait_nxt  = sdata_vld ? WW'(1) : {WW{1'b0}};
      end
      ST_WAIT: begin
        if (r_wait >= WAIT_MAX) begin
          w_state_nxt  = ST_SEARCH;
          w_wait_nxt   = {WW{1'b0}};
          w_run_nxt    = {RW{1'b0}};
          w_search_nxt = {SW{1'b0}};
        end else if (sdata_vld) begin
          w_wait_nxt = r_wait + 1'b1;
          if (w_wait_nxt >= WAIT_MAX) begin
            w_state_nxt  = ST_SEARCH;
            w_wait_nxt   = {WW{1'b0}};
            w_run_nxt    = {RW{1'b0}};
            w_search_nxt = {SW{1'b0}};
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_LOCKED: begin
        if (sdata_vld) begin
          w_loss_nxt = w_tok[2] ? {LW{1'b0}} : (r_loss + 1'b1);
          if (w_loss_nxt == LOSS_MAX) begin
            w_state_nxt  = ST_SEARCH;
            w_loss_nxt   = {LW{1'b0}};
            w_run_nxt    = {RW{1'b0}};
            w_search_nxt = {SW{1'b0}};
            w_wait_nxt   = {WW{1'b0}};
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt  = ST_SEARCH;
        w_run_nxt    = {RW{1'b0}};
        w_search_nxt = {SW{1'b0}};
        w_wait_nxt   = {WW{1'b0}};
        w_loss_nxt   = {LW{1'b0}};
      end
    endcase
  end

  // FSM state and alignment counters.
  always_ff @(posedge pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      r_state  <= ST_SEARCH;
      r_run    <= {RW{1'b0}};
      r_search <= {SW{1'b0}};
      r_wait   <= {WW{1'b0}};
      r_loss   <= {LW{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_search <= w_search_nxt;
      r_wait   <= w_wait_nxt;
      r_loss   <= w_loss_nxt;
    end
  end

  // Alignment status outputs: bitslip pulse, aligned flag and slip counter.
  always_ff @(posedge pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      r_bitslip  <= 1'b0;
      r_aligned  <= 1'b0;
      r_slip_cnt <= 4'd0;
    end else begin
      r_bitslip <= (w_state_nxt == ST_SLIP);
      r_aligned <= (w_state_nxt == ST_LOCKED);
      if (w_state_nxt == ST_LOCKED) begin
        r_slip_cnt <= 4'd0;
      end else if ((w_state_nxt == ST_SLIP) && (r_state != ST_SLIP)) begin
        r_slip_cnt <= (r_slip_cnt == 4'd9) ? 4'd0 : (r_slip_cnt + 4'd1);
      end else begin
        r_slip_cnt <= r_slip_cnt;
      end
    end
  end

  // Decoded word outputs; forced idle whenever lock is absent or being lost.
  always_ff @(posedge pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      r_dout <= 8'h00;
      r_c0   <= 1'b0;
      r_c1   <= 1'b0;
      r_de   <= 1'b0;
      r_vld  <= 1'b0;
    end else if (w_state_nxt != ST_LOCKED) begin
      r_dout <= 8'h00;
      r_c0   <= 1'b0;
      r_c1   <= 1'b0;
      r_de   <= 1'b0;
      r_vld  <= 1'b0;
    end else if ((r_state == ST_LOCKED) && sdata_vld) begin
      r_vld <= 1'b1;
      if (w_tok[2]) begin
        r_dout <= 8'h00;
        r_de   <= 1'b0;
        r_c1   <= w_tok[1];
        r_c0   <= w_tok[0];
      end else begin
        r_dout <= data_decode(sdata);
        r_de   <= 1'b1;
        r_c1   <= r_c1;
        r_c0   <= r_c0;
      end
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign bitslip  = r_bitslip;
  assign aligned  = r_aligned;
  assign slip_cnt = r_slip_cnt;
  assign dout     = r_dout;
  assign c0       = r_c0;
  assign c1       = r_c1;
  assign de       = r_de;
  assign vld      = r_vld;

endmodule
